// File: rtl/usbfs_pkt_rx_buf_if.sv
// Receive-buffer bus: line-side byte stream, verdict pulses and endpoint read port.
// slave = buffer side, master = line deserialiser / transactor / endpoint side.
interface usbfs_pkt_rx_buf_if #(
  parameter int unsigned MAX_PKT = 8
);
  localparam int unsigned NB_W  = $clog2(MAX_PKT + 1);
  localparam int unsigned IDX_W = $clog2(MAX_PKT);

  logic             i_byteValid;
  logic [7:0]       i_byte;
  logic             i_eop;
  logic             i_abort;
  logic             i_toggleClr;
  logic             o_ack;
  logic             o_nak;
  logic             o_err;
  logic             o_erValid;
  logic             i_erReady;
  logic [NB_W-1:0]  o_erRdNBytes;
  logic             i_erRdEn;
  logic [IDX_W-1:0] i_erRdIdx;
  logic [7:0]       o_erRdByte;

  modport slave (
    input  i_byteValid, i_byte, i_eop, i_abort, i_toggleClr,
    input  i_erReady, i_erRdEn, i_erRdIdx,
    output o_ack, o_nak, o_err, o_erValid, o_erRdNBytes, o_erRdByte
  );

  modport master (
    output i_byteValid, i_byte, i_eop, i_abort, i_toggleClr,
    output i_erReady, i_erRdEn, i_erRdIdx,
    input  o_ack, o_nak, o_err, o_erValid, o_erRdNBytes, o_erRdByte
  );
endinterface

// File: rtl/usbfs_pkt_rx_buf.sv
// USB FS host-to-device DATAx receive buffer: PID/length/CRC16 checks, toggle sequencing,
// held payload with indexed read port. Define USBFS_RX_CRC_EN to enable the CRC16 residual check.
module usbfs_pkt_rx_buf #(
  parameter int unsigned MAX_PKT = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  usbfs_pkt_rx_buf_if.slave bus
);
  localparam int unsigned DEPTH = MAX_PKT + 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NB_W  = $clog2(MAX_PKT + 1);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_DROP, S_HOLD} state_e;
  typedef enum logic [1:0] {V_NONE, V_ERR, V_NAK} verdict_e;

  state_e           state_q, state_d;
  verdict_e         drop_v_q, drop_v_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             exp_tog_q, exp_tog_d;
  logic             pid_tog_q, pid_tog_d;
  logic             swallow_q, swallow_d;
  logic             ack_q, ack_d;
  logic             nak_q, nak_d;
  logic             err_q, err_d;
  logic [NB_W-1:0]  nbytes_q, nbytes_d;
  logic [7:0]       rd_byte_q, rd_byte_d;
  logic [7:0]       pkt_mem_q [DEPTH];

  logic             buf_we;
  logic             pid_ok;
  logic             pid_is_data;
  logic             swallow_nxt;
  logic             crc_ok;

`ifdef USBFS_RX_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Register re-arms whenever idle so the first DATA byte starts from 0xFFFF.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE) begin
      crc_d = '1;
    end else if (buf_we) begin
      crc_d = crc16_upd(crc_q, bus.i_byte);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_ok = (crc_q == 16'hB001);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    drop_v_d    = drop_v_q;
    wr_cnt_d    = wr_cnt_q;
    exp_tog_d   = exp_tog_q;
    pid_tog_d   = pid_tog_q;
    swallow_d   = swallow_q;
    swallow_nxt = swallow_q;
    ack_d       = 1'b0;
    nak_d       = 1'b0;
    err_d       = 1'b0;
    nbytes_d    = nbytes_q;
    buf_we      = 1'b0;
    pid_ok      = (bus.i_byte[7:4] == ~bus.i_byte[3:0]);
    pid_is_data = (bus.i_byte[2:0] == 3'b011);

    case (state_q)
      S_IDLE: begin
        if (bus.i_byteValid) begin
          if (!pid_ok) begin
            state_d  = S_DROP;
            drop_v_d = V_ERR;
          end else if (!pid_is_data) begin
            state_d  = S_DROP;
            drop_v_d = V_NONE;
          end else begin
            state_d   = S_PID;
            pid_tog_d = bus.i_byte[3];
            wr_cnt_d  = '0;
          end
        end
      end

      S_PID, S_DATA: begin
        if (bus.i_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.i_byteValid) begin
          if (wr_cnt_q == CNT_W'(DEPTH)) begin
            state_d  = S_DROP;
            drop_v_d = V_ERR;
          end else begin
            buf_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            state_d  = S_DATA;
          end
        end else if (bus.i_eop) begin
          state_d = S_IDLE;
          if ((wr_cnt_q < CNT_W'(2)) || !crc_ok) begin
            err_d = 1'b1;
          end else if (pid_tog_q != exp_tog_q) begin
            ack_d = 1'b1;
          end else begin
            ack_d     = 1'b1;
            nbytes_d  = NB_W'(wr_cnt_q - CNT_W'(2));
            exp_tog_d = ~exp_tog_q;
            state_d   = S_HOLD;
          end
        end
      end

      S_DROP: begin
        if (bus.i_abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.i_eop) begin
          err_d   = (drop_v_q == V_ERR);
          nak_d   = (drop_v_q == V_NAK);
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (bus.i_byteValid && !swallow_q) begin
          swallow_nxt = 1'b1;
          drop_v_d    = (pid_ok && pid_is_data) ? V_NAK : V_NONE;
        end else if (bus.i_eop && swallow_q) begin
          swallow_nxt = 1'b0;
          nak_d       = (drop_v_q == V_NAK);
        end
        swallow_d = swallow_nxt;
        // Accepting mid-swallow hands the rest of that packet (and its NAK) over to DROP.
        if (bus.i_erReady) begin
          state_d   = swallow_nxt ? S_DROP : S_IDLE;
          swallow_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.i_toggleClr) begin
      exp_tog_d = 1'b0;
    end
  end

  always_comb begin
    rd_byte_d = rd_byte_q;
    if (bus.i_erRdEn) begin
      rd_byte_d = pkt_mem_q[CNT_W'(bus.i_erRdIdx)];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      drop_v_q  <= V_NONE;
      wr_cnt_q  <= '0;
      exp_tog_q <= 1'b0;
      pid_tog_q <= 1'b0;
      swallow_q <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      err_q     <= 1'b0;
      nbytes_q  <= '0;
      rd_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      drop_v_q  <= drop_v_d;
      wr_cnt_q  <= wr_cnt_d;
      exp_tog_q <= exp_tog_d;
      pid_tog_q <= pid_tog_d;
      swallow_q <= swallow_d;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      err_q     <= err_d;
      nbytes_q  <= nbytes_d;
      rd_byte_q <= rd_byte_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) begin
      pkt_mem_q[wr_cnt_q] <= bus.i_byte;
    end
  end

  assign bus.o_ack        = ack_q;
  assign bus.o_nak        = nak_q;
  assign bus.o_err        = err_q;
  assign bus.o_erValid    = (state_q == S_HOLD);
  assign bus.o_erRdNBytes = nbytes_q;
  assign bus.o_erRdByte   = rd_byte_q;
endmodule
